// File: rtl/simon_data_in.sv
// SIMON input packet unpacker: validates {info,count,data} packets, hands key or 1-2 blocks to the core.
// Latency: 3 cycles from in_donePKT rise to doneKEY/doneDATA, plus the in_donePKT drop wait; single-packet buffer,
// upstream backpressured by withholding in_readPKT until IDLE. Optional SIMON_PKTERR_EN adds errPKT/errCNT.
`timescale 1ns/1ps
module simon_data_in #(
  parameter int          N    = 32,
  parameter logic [3:0]  MODE = 4'h0
) (
  input  logic                   clk,
  input  logic                   R,
  input  logic                   in_donePKT,
  input  logic [(N/2+2)*8-1:0]   in_pkt,
  output logic                   in_readPKT,
  output logic                   doneDATA,
  input  logic                   readDATA,
  output logic [2*N-1:0]         dataIN,
  output logic                   doneKEY,
  input  logic                   readKEY,
  output logic [4*N-1:0]         keyIN,
  output logic [7:0]             infoIN,
  output logic [7:0]             countIN
`ifdef SIMON_PKTERR_EN
  ,
  output logic                   errPKT,
  output logic [7:0]             errCNT
`endif
);

  localparam int PW = (N/2+2)*8;

  typedef enum logic [2:0] {IDLE, ACK, CHECK, KEY, BLK0, GAP, BLK1} state_t;

  state_t        state;
  logic [PW-1:0] pkt;
  logic [7:0]    count_pkt;
  logic [7:0]    pkt_info;
  logic [7:0]    pkt_count;
  logic [4*N-1:0] pkt_data;
  logic          pkt_ok;

  assign pkt_info  = pkt[PW-1 -: 8];
  assign pkt_count = pkt[PW-9 -: 8];
  assign pkt_data  = pkt[4*N-1:0];
  assign pkt_ok    = (pkt_count == count_pkt) && (pkt_info[3:0] == MODE) && !pkt_info[4];

  always_ff @(posedge clk) begin
    if (R) begin
      state      <= IDLE;
      pkt        <= '0;
      count_pkt  <= '0;
      in_readPKT <= 1'b0;
      doneDATA   <= 1'b0;
      dataIN     <= '0;
      doneKEY    <= 1'b0;
      keyIN      <= '0;
      infoIN     <= '0;
      countIN    <= '0;
`ifdef SIMON_PKTERR_EN
      errPKT     <= 1'b0;
      errCNT     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_donePKT) begin
            pkt        <= in_pkt;
            in_readPKT <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          if (!in_donePKT) begin
            in_readPKT <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (!pkt_ok) begin
            // Bad packets were already acked upstream; just discard them.
            state <= IDLE;
`ifdef SIMON_PKTERR_EN
            errPKT <= 1'b1;
            if (errCNT != 8'hFF) errCNT <= errCNT + 8'd1;
`endif
          end else begin
            count_pkt <= count_pkt + 8'd1;
            infoIN    <= pkt_info;
            countIN   <= pkt_count;
            if (pkt_info[5]) begin
              keyIN   <= pkt_data;
              doneKEY <= 1'b1;
              state   <= KEY;
            end else begin
              dataIN   <= pkt_data[2*N-1:0];
              doneDATA <= 1'b1;
              state    <= BLK0;
            end
          end
        end
        KEY: begin
          if (readKEY) begin
            doneKEY <= 1'b0;
            state   <= IDLE;
          end
        end
        BLK0: begin
          if (readDATA) begin
            doneDATA <= 1'b0;
            state    <= pkt_info[7] ? GAP : IDLE;
          end
        end
        GAP: begin
          // The core detects blocks on the doneDATA edge, so it must see one low cycle here.
          dataIN   <= pkt_data[4*N-1:2*N];
          doneDATA <= 1'b1;
          state    <= BLK1;
        end
        BLK1: begin
          if (readDATA) begin
            doneDATA <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_data_in.sv
// Scoreboard bench for simon_data_in: driver pushes expected key/blocks, monitor consumes and compares.
`timescale 1ns/1ps
module tb_simon_data_in;
  localparam int         N    = 32;
  localparam logic [3:0] MODE = 4'h0;

  logic                 clk = 1'b0;
  logic                 R;
  logic                 in_donePKT;
  logic [(N/2+2)*8-1:0] in_pkt;
  logic                 in_readPKT;
  logic                 doneDATA;
  logic                 readDATA;
  logic [2*N-1:0]       dataIN;
  logic                 doneKEY;
  logic                 readKEY;
  logic [4*N-1:0]       keyIN;
  logic [7:0]           infoIN;
  logic [7:0]           countIN;
`ifdef SIMON_PKTERR_EN
  logic                 errPKT;
  logic [7:0]           errCNT;
`endif

  simon_data_in #(.N(N), .MODE(MODE)) dut (
    .clk(clk), .R(R), .in_donePKT(in_donePKT), .in_pkt(in_pkt), .in_readPKT(in_readPKT),
    .doneDATA(doneDATA), .readDATA(readDATA), .dataIN(dataIN),
    .doneKEY(doneKEY), .readKEY(readKEY), .keyIN(keyIN),
    .infoIN(infoIN), .countIN(countIN)
`ifdef SIMON_PKTERR_EN
    , .errPKT(errPKT), .errCNT(errCNT)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           key;
    logic [127:0] val;
    logic [7:0]   info;
    logic [7:0]   cnt;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    fails  = 0;
  bit    hold_off = 1'b0;
  bit    long_rd  = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  int    err_cnt_m = 0;
  bit    err_m = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, {125'd0, in_readPKT, doneDATA, doneKEY}, 128'd0);
    check({tag, "_data"}, {64'd0, dataIN}, 128'd0);
    check({tag, "_key"}, keyIN, 128'd0);
    check({tag, "_hdr"}, {112'd0, infoIN, countIN}, 128'd0);
  endtask

  // Reference model: a packet is accepted iff its count matches the running count, its
  // mode matches and it is an input-direction packet. Accepted packets yield a key or 1-2 blocks.
  task automatic model(input logic [7:0] info, input logic [7:0] cnt, input logic [127:0] data);
    item_t it;
    if (cnt == exp_cnt && info[3:0] == MODE && !info[4]) begin
      exp_cnt = exp_cnt + 8'd1;
      it.info = info;
      it.cnt  = cnt;
      if (info[5]) begin
        it.key = 1'b1; it.val = data; exp_q.push_back(it);
      end else begin
        it.key = 1'b0; it.val = {64'd0, data[63:0]}; exp_q.push_back(it);
        if (info[7]) begin
          it.val = {64'd0, data[127:64]}; exp_q.push_back(it);
        end
      end
    end else begin
      err_m = 1'b1;
      if (err_cnt_m < 255) err_cnt_m++;
    end
  endtask

  task automatic send(input logic [7:0] info, input logic [7:0] cnt, input logic [127:0] data,
                      input bit chk_ack);
    int n;
    model(info, cnt, data);
    in_pkt     = {info, cnt, data};
    in_donePKT = 1'b1;
    @(negedge clk);
    if (chk_ack) check("ack_latency", {127'd0, in_readPKT}, 128'd1);
    n = 0;
    while (!in_readPKT && n < 300) begin @(negedge clk); n++; end
    check("ack_seen", {127'd0, in_readPKT}, 128'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_donePKT = 1'b0;
    in_pkt     = {$urandom, $urandom, $urandom, $urandom, 16'h0};
    n = 0;
    while (in_readPKT && n < 50) begin @(negedge clk); n++; end
    check("ack_release", {127'd0, in_readPKT}, 128'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("drain", exp_q.size(), 128'd0);
  endtask

  task automatic check_err();
`ifdef SIMON_PKTERR_EN
    check("errPKT", {127'd0, errPKT}, {127'd0, err_m});
    check("errCNT", {120'd0, errCNT}, err_cnt_m);
`endif
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_random(input bit allow_bad);
    logic [7:0] info, cnt;
    info = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 1'b0, MODE};
    cnt  = exp_cnt;
    if (allow_bad && $urandom_range(0, 4) == 0) begin
      case ($urandom_range(0, 2))
        0:       cnt = exp_cnt + 8'($urandom_range(1, 255));
        1:       info[3:0] = MODE ^ 4'($urandom_range(1, 15));
        default: info[4] = 1'b1;
      endcase
    end
    send(info, cnt, rnd128(), 1'b0);
  endtask

  // Monitor: compares each presented key/block against the scoreboard, then consumes it.
  initial begin
    item_t it;
    logic [127:0] v0;
    logic [1:0] kind;
    bit hi;
    readDATA = 1'b0;
    readKEY  = 1'b0;
    forever begin
      @(negedge clk);
      if (doneDATA && doneKEY) check("flag_excl", 128'd3, 128'd0);
      if (!hold_off && !R && (doneDATA || doneKEY)) begin
        kind = {doneKEY, doneDATA};
        v0   = doneKEY ? keyIN : {64'd0, dataIN};
        if (exp_q.size() == 0) begin
          check("unexpected_out", {126'd0, kind}, 128'd0);
        end else begin
          it = exp_q.pop_front();
          check(it.key ? "key_val" : "data_val", v0, it.val);
          check("kind", {126'd0, kind}, it.key ? 128'd2 : 128'd1);
          check("hdr", {112'd0, infoIN, countIN}, {112'd0, it.info, it.cnt});
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("stable", doneKEY ? keyIN : {64'd0, dataIN}, v0);
        if (long_rd) begin
          readDATA = 1'b1;
          hi = 1'b0;
          @(negedge clk);
          hi = doneDATA;
          repeat (4) begin @(negedge clk); hi = hi | doneDATA | doneKEY; end
          readDATA = 1'b0;
          check("no_extra_block", {127'd0, hi}, 128'd0);
        end else begin
          readDATA = kind[0];
          readKEY  = kind[1];
          @(negedge clk);
          readDATA = 1'b0;
          readKEY  = 1'b0;
          check("done_drop", {126'd0, doneKEY, doneDATA}, 128'd0);
        end
      end
    end
  end

  initial begin
    int n;
    R          = 1'b1;
    in_donePKT = 1'b0;
    in_pkt     = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    R = 1'b0;
    @(negedge clk);

    // Key packet with the SIMON 64/128 test key
    send(8'h20, 8'd0, 128'h1b1a1918_13121110_0b0a0908_03020100, 1'b1);
    wait_drain();
    // Two-block data packet
    send(8'h80, 8'd1, rnd128(), 1'b0);
    wait_drain();
    // Single-block packet with readDATA held for 5 cycles
    long_rd = 1'b1;
    send(8'h00, 8'd2, rnd128(), 1'b0);
    wait_drain();
    long_rd = 1'b0;
    // Bad count and output-direction packet, then a valid one proving the count held at 3
    send(8'h00, 8'd7, rnd128(), 1'b0);
    send(8'h10, 8'd3, rnd128(), 1'b0);
    send(8'h00, 8'd3, rnd128(), 1'b0);
    wait_drain();
    check_err();

    // Reset while a block is presented
    hold_off = 1'b1;
    send(8'h80, 8'd4, rnd128(), 1'b0);
    n = 0;
    while (!doneDATA && n < 50) begin @(negedge clk); n++; end
    check("blk0_reached", {127'd0, doneDATA}, 128'd1);
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    check_zero("midreset");
    exp_q.delete();
    exp_cnt   = 8'd0;
    err_m     = 1'b0;
    err_cnt_m = 0;
    check_err();
    hold_off = 1'b0;

    // 256 valid packets from count 0, then count 0 again must be accepted
    for (int i = 0; i < 256; i++) send_random(1'b0);
    send(8'h00, 8'd0, rnd128(), 1'b0);
    wait_drain();

    for (int i = 0; i < 150; i++) send_random(1'b1);
    wait_drain();
    check_err();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
